// File: rtl/poly_dispatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : poly_dispatch_pkg
//  Purpose  : Shared types and constants for the polynomial job dispatcher:
//             operand widths, default queue depth / watchdog limit, the
//             dispatcher FSM state encoding and the queued job record.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package poly_dispatch_pkg;

    localparam int X_W         = 8;    // signed operand x
    localparam int COEF_W      = 16;   // signed coefficients a, b, c
    localparam int ISSUED_W    = 16;   // issued-job counter width
    localparam int DEPTH_DEF   = 4;    // default job-queue depth
    localparam int TIMEOUT_DEF = 255;  // default WAIT_VALID watchdog limit

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ISSUE      = 2'd1,
        ST_WAIT_VALID = 2'd2,
        ST_WAIT_READY = 2'd3
    } state_e;

    typedef struct packed {
        logic signed [X_W-1:0]    x;
        logic signed [COEF_W-1:0] a;
        logic signed [COEF_W-1:0] b;
        logic signed [COEF_W-1:0] c;
    } job_t;

endpackage
`default_nettype wire

// File: rtl/poly_job_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : poly_job_fifo
//  Purpose  : Circular FIFO of operand sets {x,a,b,c}. A push while full is
//             still accepted when a pop happens in the same cycle.
//  Ports    : clk, rst_n          - clock, async active-low reset
//             push_i, data_i      - write request and operand set
//             pop_i               - read request (head advances)
//             data_o              - head entry (valid when empty_o = 0)
//             full_o, empty_o     - occupancy flags
//             count_o             - occupancy, 0..DEPTH
//             drop_o              - this cycle's push is being discarded
//  Revision : 1.0 - initial release
// ============================================================================
module poly_job_fifo
    import poly_dispatch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  job_t                     data_i,
    input  logic                     pop_i,
    output job_t                     data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     drop_o
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    job_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (count_q == CNT_FULL);
    assign w_empty   = (count_q == '0);
    assign w_do_pop  = pop_i && !w_empty;
    // A pop frees the head slot this very edge, so a push into a full
    // queue can still land.
    assign w_do_push = push_i && (!w_full || w_do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (w_do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it is written.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = w_full;
    assign empty_o = w_empty;
    assign count_o = count_q;
    assign drop_o  = push_i && w_full && !w_do_pop;

endmodule
`default_nettype wire

// File: rtl/poly_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : poly_dispatch
//  Purpose  : Queues polynomial operand sets and hands them one at a time to
//             a poly_solver: pops the head into operand registers, pulses
//             enable, waits for the result handshake, aborts via watchdog.
//  Ports    : clk, rst_n                  - clock, async active-low reset
//             push_i, x_in_i..c_in_i      - operand-set write
//             full_o, empty_o, count_o    - queue status
//             solver_ready_i/valid_i      - poly_solver handshake
//             enable_o, x_o..c_o          - start pulse and held operands
//             busy_o                      - job in flight
//             overflow_o, timeout_o       - sticky error flags
//             issued_o                    - jobs issued (wraps)
//  Revision : 1.0 - initial release
// ============================================================================
module poly_dispatch
    import poly_dispatch_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push_i,
    input  logic signed [X_W-1:0]     x_in_i,
    input  logic signed [COEF_W-1:0]  a_in_i,
    input  logic signed [COEF_W-1:0]  b_in_i,
    input  logic signed [COEF_W-1:0]  c_in_i,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [$clog2(DEPTH):0]    count_o,
    input  logic                      solver_ready_i,
    input  logic                      solver_valid_i,
    output logic                      enable_o,
    output logic signed [X_W-1:0]     x_o,
    output logic signed [COEF_W-1:0]  a_o,
    output logic signed [COEF_W-1:0]  b_o,
    output logic signed [COEF_W-1:0]  c_o,
    output logic                      busy_o,
    output logic                      overflow_o,
    output logic                      timeout_o,
    output logic [ISSUED_W-1:0]       issued_o
);

    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    // The watchdog holds 0 in the first WAIT_VALID cycle, so reaching
    // TIMEOUT-1 marks the TIMEOUT-th cycle spent waiting.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic [ISSUED_W-1:0] issued_q;
    logic                overflow_q;
    logic                timeout_q;
    job_t                job_q;

    job_t w_job_in;
    job_t w_head;
    logic w_empty;
    logic w_pop;
    logic w_drop;
    logic w_abort;

    assign w_job_in = '{x: x_in_i, a: a_in_i, b: b_in_i, c: c_in_i};

    // Head is taken only on the IDLE->ISSUE edge.
    assign w_pop = (state_q == ST_IDLE) && !w_empty && solver_ready_i;

    poly_job_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_i),
        .data_i  (w_job_in),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (full_o),
        .empty_o (w_empty),
        .count_o (count_o),
        .drop_o  (w_drop)
    );

    always_comb begin
        state_d = state_q;
        wd_d    = '0;
        w_abort = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_pop) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_VALID;
            end
            ST_WAIT_VALID: begin
                // A result arriving on the last allowed cycle still wins.
                if (solver_valid_i) begin
                    state_d = ST_WAIT_READY;
                end else if (wd_q == WD_LAST) begin
                    state_d = ST_IDLE;
                    w_abort = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_WAIT_READY: begin
                if (solver_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wd_q       <= '0;
            issued_q   <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
            job_q      <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            if (state_q == ST_ISSUE) begin
                issued_q <= issued_q + 1'b1;
            end
            if (w_drop) begin
                overflow_q <= 1'b1;
            end
            if (w_abort) begin
                timeout_q <= 1'b1;
            end
            if (w_pop) begin
                job_q <= w_head;
            end
        end
    end

    assign empty_o    = w_empty;
    assign enable_o   = (state_q == ST_ISSUE);
    assign busy_o     = (state_q != ST_IDLE);
    assign x_o        = job_q.x;
    assign a_o        = job_q.a;
    assign b_o        = job_q.b;
    assign c_o        = job_q.c;
    assign overflow_o = overflow_q;
    assign timeout_o  = timeout_q;
    assign issued_o   = issued_q;

endmodule
`default_nettype wire

// File: tb/tb_poly_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_poly_dispatch
//  Purpose  : Self-checking bench for poly_dispatch. A job-level model
//             (queue of operand sets plus a job lifecycle) predicts every
//             output each cycle; a small poly_solver emulation drives the
//             handshake and evaluates y = a*x*x + b*x + c.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_poly_dispatch;
    import poly_dispatch_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 255;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               push_i = 1'b0;
    logic signed [7:0]  x_in_i = '0;
    logic signed [15:0] a_in_i = '0, b_in_i = '0, c_in_i = '0;
    logic               full_o, empty_o;
    logic [2:0]         count_o;
    logic               solver_ready_i = 1'b0, solver_valid_i = 1'b0;
    logic               enable_o;
    logic signed [7:0]  x_o;
    logic signed [15:0] a_o, b_o, c_o;
    logic               busy_o, overflow_o, timeout_o;
    logic [15:0]        issued_o;

    always #5 clk = ~clk;

    poly_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .push_i         (push_i),
        .x_in_i         (x_in_i),
        .a_in_i         (a_in_i),
        .b_in_i         (b_in_i),
        .c_in_i         (c_in_i),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .count_o        (count_o),
        .solver_ready_i (solver_ready_i),
        .solver_valid_i (solver_valid_i),
        .enable_o       (enable_o),
        .x_o            (x_o),
        .a_o            (a_o),
        .b_o            (b_o),
        .c_o            (c_o),
        .busy_o         (busy_o),
        .overflow_o     (overflow_o),
        .timeout_o      (timeout_o),
        .issued_o       (issued_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic int poly(input job_t j);
        int x;
        x = $signed(j.x);
        return $signed(j.a) * x * x + $signed(j.b) * x + $signed(j.c);
    endfunction

    // ---------------- job-level reference model ----------------
    job_t        mq[$];
    bit          m_inflight = 0;   // a job has been taken from the queue
    int          m_age = 0;        // 0 = start-pulse cycle, 1 = afterwards
    bit          m_gotv = 0;       // result seen, waiting for solver ready
    int          m_wcnt = 0;       // cycles waited for a result
    job_t        m_cur = '0;
    int          m_cur_y = 0;
    logic [15:0] m_issued = '0;
    bit          m_ovf = 0, m_tmo = 0;

    always @(posedge clk or negedge rst_n) begin : model
        bit   take;
        job_t nj;
        if (!rst_n) begin
            mq.delete();
            m_inflight = 0; m_age = 0; m_gotv = 0; m_wcnt = 0;
            m_cur = '0; m_cur_y = 0; m_issued = '0; m_ovf = 0; m_tmo = 0;
        end else begin
            take = !m_inflight && (mq.size() > 0) && solver_ready_i;
            if (m_inflight) begin
                if (m_age == 0) begin
                    m_age = 1; m_wcnt = 0; m_issued = m_issued + 16'd1;
                end else if (!m_gotv) begin
                    if (solver_valid_i) m_gotv = 1;
                    else begin
                        m_wcnt++;
                        if (m_wcnt == TIMEOUT) begin m_inflight = 0; m_tmo = 1; end
                    end
                end else if (solver_ready_i) begin
                    m_inflight = 0;
                end
            end else if (take) begin
                m_cur = mq.pop_front(); m_cur_y = poly(m_cur);
                m_inflight = 1; m_age = 0; m_gotv = 0;
            end
            if (push_i) begin
                nj = '{x: x_in_i, a: a_in_i, b: b_in_i, c: c_in_i};
                if (mq.size() < DEPTH) mq.push_back(nj);
                else m_ovf = 1;
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    int n_en = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (enable_o) n_en++;
            check("count",    count_o,    mq.size());
            check("full",     full_o,     mq.size() == DEPTH);
            check("empty",    empty_o,    mq.size() == 0);
            check("enable",   enable_o,   m_inflight && m_age == 0);
            check("busy",     busy_o,     m_inflight);
            check("x",        x_o,        m_cur.x);
            check("a",        a_o,        m_cur.a);
            check("b",        b_o,        m_cur.b);
            check("c",        c_o,        m_cur.c);
            check("issued",   issued_o,   m_issued);
            check("overflow", overflow_o, m_ovf);
            check("timeout",  timeout_o,  m_tmo);
        end
    end

    // ---------------- poly_solver emulation ----------------
    // mode 0: never ready; 1: normal solver; 2: ready but never valid
    int sol_mode = 0;
    bit sol_busy = 0;
    int sol_lat = 0;
    int sx, sa, sb, sc;
    int results = 0;
    int last_y = 0;
    int ylog[32];

    always @(negedge clk) begin
        if (!rst_n) begin
            sol_busy = 0; solver_ready_i = 0; solver_valid_i = 0;
        end else begin
            solver_valid_i = 0;
            case (sol_mode)
                0: begin solver_ready_i = 0; sol_busy = 0; end
                2: begin solver_ready_i = 1; sol_busy = 0; end
                default: begin
                    if (sol_busy) begin
                        if (sol_lat == 0) begin
                            sol_busy = 0; solver_valid_i = 1; solver_ready_i = 1;
                            last_y = sa * sx * sx + sb * sx + sc;
                            check("y", last_y, m_cur_y);
                            if (results < 32) ylog[results] = last_y;
                            results++;
                        end else sol_lat--;
                    end else if (enable_o) begin
                        sx = $signed(x_o); sa = $signed(a_o);
                        sb = $signed(b_o); sc = $signed(c_o);
                        sol_busy = 1; sol_lat = 1; solver_ready_i = 0;
                    end else solver_ready_i = 1;
                end
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_job(input logic signed [7:0] x, input logic signed [15:0] a,
                            input logic signed [15:0] b, input logic signed [15:0] c,
                            input bit wait_full);
        int g;
        g = 0;
        @(negedge clk); #1;
        if (wait_full) begin
            while (full_o && g < 100) begin
                push_i = 0; @(negedge clk); #1; g++;
            end
            check("push_wait_in_time", g < 100, 1);
        end
        push_i = 1; x_in_i = x; a_in_i = a; b_in_i = b; c_in_i = c;
    endtask

    task automatic push_off();
        @(negedge clk); #1;
        push_i = 0;
    endtask

    function automatic bit cond(input int what);
        case (what)
            0:       return enable_o;
            1:       return timeout_o;
            default: return !busy_o && empty_o;
        endcase
    endfunction

    task automatic wait_for(input int what, input int budget, input string tag, output int n);
        n = 0;
        while (!cond(what) && n < budget) begin
            @(negedge clk); n++;
        end
        check(tag, n < budget, 1);
    endtask

    task automatic apply_reset();
        @(negedge clk); #1; rst_n = 0;
        @(negedge clk); #1; rst_n = 1;
    endtask

    task automatic chk_reset(input string t);
        check({t, "_count"},  count_o,    0);
        check({t, "_empty"},  empty_o,    1);
        check({t, "_full"},   full_o,     0);
        check({t, "_enable"}, enable_o,   0);
        check({t, "_busy"},   busy_o,     0);
        check({t, "_xabc"},   {x_o, a_o[7:0], b_o[7:0], c_o[7:0]}, 0);
        check({t, "_abc_hi"}, {a_o[15:8], b_o[15:8], c_o[15:8]}, 0);
        check({t, "_issued"}, issued_o,   0);
        check({t, "_ovf"},    overflow_o, 0);
        check({t, "_tmo"},    timeout_o,  0);
    endtask

    logic signed [7:0]  vx [8] = '{8'sd2, -8'sd1, 8'sd0, 8'sd10, -8'sd128, 8'sd127, -8'sd5, 8'sd3};
    logic signed [15:0] va [8] = '{16'sd1, 16'sd3, 16'sd100, -16'sd2, 16'sd1, 16'sd2, -16'sd32768, 16'sd7};
    logic signed [15:0] vb [8] = '{16'sd2, 16'sd4, -16'sd7, 16'sd5, 16'sd0, -16'sd1, 16'sd32767, -16'sd3};
    logic signed [15:0] vc [8] = '{16'sd3, 16'sd5, -16'sd9, 16'sd1, 16'sd0, 16'sd7, -16'sd1, 16'sd32767};
    int                 vy [8] = '{11, 4, -9, -149, 16384, 32138, -983036, 32821};

    initial begin
        int n, base_res, base_en;

        // Power-on reset values
        repeat (3) @(negedge clk);
        #1;
        chk_reset("por");
        rst_n = 1;

        // Single job through the solver
        sol_mode = 1;
        base_res = results; base_en = n_en;
        push_job(8'sd2, 16'sd1, 16'sd2, 16'sd3, 0);
        push_off();
        wait_for(2, 100, "t1_idle", n);
        check("t1_issued", issued_o, 1);
        check("t1_x", x_o, 2);
        check("t1_a", a_o, 1);
        check("t1_b", b_o, 2);
        check("t1_c", c_o, 3);
        check("t1_y", last_y, 11);
        check("t1_results", results - base_res, 1);
        check("t1_enables", n_en - base_en, 1);

        // Fill the queue with the solver stalled, then overflow
        sol_mode = 0;
        for (int i = 0; i < 4; i++) push_job(8'sd1, 16'(i), 16'sd0, 16'sd0, 0);
        push_off();
        #1;
        check("t2_full", full_o, 1);
        check("t2_count", count_o, 4);
        check("t2_ovf_clear", overflow_o, 0);
        push_job(8'sd9, 16'sd9, 16'sd9, 16'sd9, 0);
        push_off();
        #1;
        check("t2_ovf", overflow_o, 1);
        check("t2_count_after", count_o, 4);

        // Push into a full queue on the same edge as the pop
        apply_reset();
        for (int i = 0; i < 4; i++) push_job(-8'sd2, 16'(i + 1), -16'sd3, 16'sd4, 0);
        @(negedge clk); #1; push_i = 0; sol_mode = 1;
        push_job(8'sd5, 16'sd6, 16'sd7, 16'sd8, 0);
        push_off();
        check("t3_count", count_o, 4);
        check("t3_full", full_o, 1);
        check("t3_ovf", overflow_o, 0);
        check("t3_enable", enable_o, 1);
        wait_for(2, 200, "t3_idle", n);
        check("t3_issued", issued_o, 5);
        check("t3_last_x", x_o, 5);

        // Watchdog abort, then the next job still goes out
        apply_reset();
        sol_mode = 2;
        push_job(8'sd1, 16'sd1, 16'sd1, 16'sd1, 0);
        push_job(8'sd3, 16'sd3, 16'sd3, 16'sd3, 0);
        push_off();
        wait_for(0, 20, "t4_en1", n);
        wait_for(1, 400, "t4_tmo", n);
        check("t4_tmo_cycles", n, 256);
        check("t4_idle_at_tmo", busy_o, 0);
        wait_for(0, 20, "t4_en2", n);
        check("t4_en2_delay", n, 1);
        check("t4_x2", x_o, 3);
        wait_for(2, 400, "t4_idle", n);
        check("t4_issued", issued_o, 2);
        check("t4_tmo_sticky", timeout_o, 1);

        // Asynchronous reset while waiting for a result with 3 queued
        apply_reset();
        sol_mode = 2;
        for (int i = 0; i < 4; i++) push_job(8'(i + 1), 16'sd2, 16'sd2, 16'sd2, 0);
        push_off();
        check("t5_count", count_o, 3);
        check("t5_busy", busy_o, 1);
        check("t5_enable", enable_o, 0);
        #2; rst_n = 0;
        #1;
        chk_reset("t5_async");
        @(negedge clk); #1; rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_no_enable", enable_o, 0);
        end

        // Eight vectors through dispatcher and solver
        apply_reset();
        sol_mode = 1;
        base_res = results; base_en = n_en;
        for (int i = 0; i < 8; i++) push_job(vx[i], va[i], vb[i], vc[i], 1);
        push_off();
        wait_for(2, 400, "t6_idle", n);
        check("t6_issued", issued_o, 8);
        check("t6_enables", n_en - base_en, 8);
        check("t6_results", results - base_res, 8);
        for (int i = 0; i < 8; i++) begin
            if (base_res + i < 32) check($sformatf("t6_y%0d", i), ylog[base_res + i], vy[i]);
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/poly_dispatch.md
POLY_DISPATCH -- requirements
Module: poly_dispatch

Interface
REQ-001 Parameter DEPTH, default 4, meaning number of operand-set entries in the job queue (power of two, 2..16).
REQ-002 Parameter TIMEOUT, default 255, meaning maximum cycles spent waiting for solver_valid before abort.
REQ-003 clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 push  input  1  write request; one operand set captured per cycle with push=1.
REQ-006 x_in  input  8  signed operand x; a_in, b_in, c_in  input  16 each  signed coefficients.
REQ-007 full  output  1  queue holds DEPTH entries; empty  output  1  queue holds 0 entries.
REQ-008 count  output  clog2(DEPTH)+1  current queue occupancy.
REQ-009 solver_ready  input  1  poly_solver idle/ready indication; solver_valid  input  1  poly_solver result-valid indication.
REQ-010 enable  output  1  start pulse to poly_solver.
REQ-011 x  output  8, a, b, c  output  16 each  signed operands presented to poly_solver.
REQ-012 busy  output  1  a job is in flight (state not IDLE).
REQ-013 overflow  output  1  sticky: a push was dropped; timeout  output  1  sticky: a job aborted by watchdog.
REQ-014 issued  output  16  number of jobs issued since reset, wraps modulo 2^16.

Function
REQ-015 Queue SHALL be a circular FIFO of {x,a,b,c} with read/write pointers wrapping from DEPTH-1 to 0.
REQ-016 push with full=0 SHALL write the entry and increment count in the same cycle's edge.
REQ-017 push with full=1 SHALL drop the data and set overflow, unless a pop occurs in that same cycle, in which case the push SHALL be accepted and count stays DEPTH.
REQ-018 Simultaneous push and pop with 0<count<DEPTH SHALL leave count unchanged.
REQ-019 FSM states: IDLE, ISSUE, WAIT_VALID, WAIT_READY.
REQ-020 IDLE -> ISSUE when empty=0 and solver_ready=1; on this edge head entry SHALL be popped into x/a/b/c registers.
REQ-021 ISSUE: enable=1 for exactly one cycle, issued increments; next state WAIT_VALID unconditionally.
REQ-022 WAIT_VALID -> WAIT_READY when solver_valid=1; watchdog counter SHALL count cycles in WAIT_VALID and on reaching TIMEOUT go to IDLE and set timeout.
REQ-023 WAIT_READY -> IDLE when solver_ready=1 (same cycle as valid allowed: minimum one cycle in WAIT_READY).
REQ-024 enable SHALL be 0 in every state other than ISSUE; back-to-back jobs SHALL have at least 3 cycles between enable pulses.
REQ-025 x/a/b/c SHALL be registered and remain stable from ISSUE until the next IDLE->ISSUE transition.
REQ-026 Arithmetic: count, pointers, watchdog and issued SHALL be unsigned; operand data passes unmodified, sign preserved.
REQ-027 Sticky flags SHALL clear only on reset.

Reset
REQ-028 On reset=0, asynchronously: state IDLE, pointers 0, count 0, empty=1, full=0, enable=0, busy=0, x/a/b/c=0, issued=0, overflow=0, timeout=0, watchdog=0.
REQ-029 Reset mid-job SHALL discard queued entries and the in-flight job; no enable pulse SHALL appear in the first cycle after release.

Structure
REQ-030 Shared package SHALL hold the FSM state encoding, operand widths (8/16) and default DEPTH/TIMEOUT constants.
REQ-031 The FIFO SHALL be one sub-module, poly_job_fifo; the FSM, watchdog and counters stay in poly_dispatch.

Verification
REQ-032 Reset, push (x=2,a=1,b=2,c=3), solver model ready -> one enable pulse, x=2 a=1 b=2 c=3 held, issued=1, poly_solver y=11.
REQ-033 Push 4 jobs back-to-back with solver_ready=0 -> full=1, count=4; 5th push -> overflow=1, count=4.
REQ-034 Full queue, push coincident with IDLE->ISSUE pop -> push accepted, count=4, overflow=0.
REQ-035 solver_valid held 0 after issue -> timeout=1 after 255 WAIT_VALID cycles, state IDLE, next job issued.
REQ-036 reset=0 asserted in WAIT_VALID with 3 entries queued -> all outputs at reset values immediately, empty=1, no enable after release.
REQ-037 Drive 8 vectors through poly_dispatch into poly_solver -> 8 enable pulses, issued=8, each y matches a*x*x+b*x+c.
